// File: rtl/riscv_mem_arbiter_pkg.sv
// Shared types for the byte-serialising data BRAM arbiter.
package riscv_mem_arbiter_pkg;

   // Access size selector carried with every request.
   typedef enum logic [1:0] {
      MASK_B = 2'b00,
      MASK_H = 2'b01,
      MASK_W = 2'b10,
      MASK_X = 2'b11
   } MASK_SEL;

   // Arbiter sequencer states.
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      DRAIN = 2'b10,
      DONE  = 2'b11
   } ArbState;

   localparam int BYTES_PER_WORD = 4;

   // Number of byte beats for an access size; anything but B/H is a full word.
   function automatic logic [2:0] mask_len(input MASK_SEL m);
      case (m)
         MASK_B:  return 3'd1;
         MASK_H:  return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/riscv_mem_arbiter_rr.sv
// Two-way round-robin grant; only meaningful while the sequencer is idle.
module riscv_rr_arbiter
   import riscv_mem_arbiter_pkg::*;
(
   input  logic en,
   input  logic req0,
   input  logic req1,
   input  logic last,
   output logic gnt_vld,
   output logic gnt
);

   // On a tie the port that was not served last wins.
   always_comb begin
      gnt_vld = en & (req0 | req1);
      gnt     = 1'b0;
      if (req0 & req1)
         gnt = ~last;
      else if (req1)
         gnt = 1'b1;
   end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares the byte-wide data BRAM between the LSU (port 0) and the loader/DMA
// (port 1), splitting word/half/byte accesses into consecutive byte beats.
module riscv_mem_arbiter
   import riscv_mem_arbiter_pkg::*;
#(
   parameter int ADDR_LENGTH = 32,
   parameter int WORD_LENGTH = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req0,
   input  logic                   req1,
   input  logic                   we0,
   input  logic                   we1,
   input  logic [ADDR_LENGTH-1:0] addr0,
   input  logic [ADDR_LENGTH-1:0] addr1,
   input  logic [WORD_LENGTH-1:0] wdata0,
   input  logic [WORD_LENGTH-1:0] wdata1,
   input  MASK_SEL                mask0,
   input  MASK_SEL                mask1,
   output logic                   ack0,
   output logic                   ack1,
   output logic [WORD_LENGTH-1:0] rdata0,
   output logic [WORD_LENGTH-1:0] rdata1,
   output logic                   bram_we,
   output logic [ADDR_LENGTH-1:0] bram_waddr,
   output logic [ADDR_LENGTH-1:0] bram_raddr,
   output logic [7:0]             bram_wdata,
   input  logic [7:0]             bram_dout,
   output logic                   busy,
   output logic                   grant
);

   ArbState                             state;
   logic                                gnt_vld;
   logic                                gnt_port;
   logic                                cur_we;
   logic [ADDR_LENGTH-1:0]              cur_addr;
   logic [BYTES_PER_WORD-1:0][7:0]      cur_wdata;
   logic [BYTES_PER_WORD-1:0][7:0]      rbuf;
   logic [BYTES_PER_WORD-1:0][7:0]      rword;
   logic [2:0]                          num;
   logic [1:0]                          idx;
   logic [1:0]                          idx_n;
   logic [1:0]                          last_lane;
   logic                                sel_we;
   logic [ADDR_LENGTH-1:0]              sel_addr;
   logic [WORD_LENGTH-1:0]              sel_wdata;
   MASK_SEL                             sel_mask;

   riscv_rr_arbiter u_arb (
      .en      (state == IDLE),
      .req0    (req0),
      .req1    (req1),
      .last    (grant),
      .gnt_vld (gnt_vld),
      .gnt     (gnt_port)
   );

   // Steer the winning port's request fields toward the latch.
   always_comb begin
      sel_we    = gnt_port ? we1    : we0;
      sel_addr  = gnt_port ? addr1  : addr0;
      sel_wdata = gnt_port ? wdata1 : wdata0;
      sel_mask  = gnt_port ? mask1  : mask0;
   end

   assign idx_n     = idx + 2'd1;
   assign last_lane = 2'(num - 3'd1);

   // Final read word: earlier lanes from the buffer, last lane straight off the BRAM.
   always_comb begin
      rword            = rbuf;
      rword[last_lane] = bram_dout;
   end

   // Sequencer: latch a granted request, walk its bytes, collect read lanes, ack.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         ack0       <= 1'b0;
         ack1       <= 1'b0;
         rdata0     <= '0;
         rdata1     <= '0;
         bram_we    <= 1'b0;
         bram_waddr <= '0;
         bram_raddr <= '0;
         bram_wdata <= '0;
         busy       <= 1'b0;
         grant      <= 1'b1;
         cur_we     <= 1'b0;
         cur_addr   <= '0;
         cur_wdata  <= '0;
         rbuf       <= '0;
         num        <= 3'd4;
         idx        <= '0;
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         case (state)
            IDLE: begin
               if (gnt_vld) begin
                  grant      <= gnt_port;
                  cur_we     <= sel_we;
                  cur_addr   <= sel_addr;
                  cur_wdata  <= sel_wdata;
                  num        <= mask_len(sel_mask);
                  idx        <= '0;
                  rbuf       <= '0;
                  // byte 0 goes out in the first ISSUE cycle
                  bram_we    <= sel_we;
                  bram_waddr <= sel_addr;
                  bram_raddr <= sel_addr;
                  bram_wdata <= sel_wdata[7:0];
                  busy       <= 1'b1;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               // BRAM read data lags the address by one cycle
               if (idx != 2'd0)
                  rbuf[idx - 2'd1] <= bram_dout;
               if (3'(idx) == num - 3'd1) begin
                  bram_we <= 1'b0;
                  if (cur_we) begin
                     ack0  <= ~grant;
                     ack1  <= grant;
                     state <= DONE;
                  end else begin
                     state <= DRAIN;
                  end
               end else begin
                  idx        <= idx_n;
                  bram_we    <= cur_we;
                  bram_waddr <= cur_addr + ADDR_LENGTH'(idx_n);
                  bram_raddr <= cur_addr + ADDR_LENGTH'(idx_n);
                  bram_wdata <= cur_wdata[idx_n];
               end
            end
            DRAIN: begin
               rbuf <= rword;
               if (grant)
                  rdata1 <= rword;
               else
                  rdata0 <= rword;
               ack0  <= ~grant;
               ack1  <= grant;
               state <= DONE;
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed scoreboard bench for riscv_mem_arbiter with a registered byte BRAM model.
module tb_riscv_mem_arbiter;
   import riscv_mem_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req0, req1, we0, we1;
   logic [31:0] addr0, addr1, wdata0, wdata1;
   MASK_SEL     mask0, mask1;
   logic        ack0, ack1, bram_we, busy, grant;
   logic [31:0] rdata0, rdata1, bram_waddr, bram_raddr;
   logic [7:0]  bram_wdata;
   logic [7:0]  bram_dout = 8'h00;

   riscv_mem_arbiter #(.ADDR_LENGTH(32), .WORD_LENGTH(32)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .mask0(mask0), .mask1(mask1),
      .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
      .bram_we(bram_we), .bram_waddr(bram_waddr), .bram_raddr(bram_raddr),
      .bram_wdata(bram_wdata), .bram_dout(bram_dout),
      .busy(busy), .grant(grant)
   );

   always #5 clk = ~clk;

   // Registered byte BRAM; low 12 address bits are enough for the addresses used.
   logic [7:0] mem [4096] = '{default: 8'h00};
   always @(posedge clk) begin
      bram_dout <= mem[bram_raddr[11:0]];
      if (bram_we) mem[bram_waddr[11:0]] <= bram_wdata;
   end

   typedef struct { logic [31:0] addr; logic [7:0] data; } wr_t;
   typedef struct { bit port; bit we; logic [31:0] rdata; int lat; int push_cyc; } rsp_t;

   wr_t         wq[$];
   rsp_t        rq[$];
   int          n_tests = 0, n_fail = 0, cyc = 0, last_ack = -100;
   logic [31:0] cur_rd [2];
   bit          hold_req = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock; then check any BRAM write beat and any ack against the scoreboard.
   task automatic step();
      wr_t  w;
      rsp_t r;
      int   start;
      @(posedge clk); #1;
      cyc++;
      if (bram_we === 1'b1) begin
         if (wq.size() == 0) chk("bram_we_spurious", 64'(bram_we), 64'd0);
         else begin
            w = wq.pop_front();
            chk("bram_waddr", 64'(bram_waddr), 64'(w.addr));
            chk("bram_raddr", 64'(bram_raddr), 64'(w.addr));
            chk("bram_wdata", 64'(bram_wdata), 64'(w.data));
         end
      end
      if (ack0 === 1'b1 || ack1 === 1'b1) begin
         if (rq.size() == 0) chk("ack_spurious", 64'({ack1, ack0}), 64'd0);
         else begin
            r = rq.pop_front();
            start = (r.push_cyc > last_ack) ? r.push_cyc : last_ack + 1;
            chk("ack_port", 64'({ack1, ack0}), r.port ? 64'd2 : 64'd1);
            chk("ack_cycle", 64'(cyc), 64'(start + r.lat));
            if (!r.we) cur_rd[r.port] = r.rdata;
            chk("rdata0", 64'(rdata0), 64'(cur_rd[0]));
            chk("rdata1", 64'(rdata1), 64'(cur_rd[1]));
            last_ack = cyc;
            if (!hold_req) begin
               if (r.port) req1 = 1'b0; else req0 = 1'b0;
            end
         end
      end
   endtask

   task automatic start_access(input bit port, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata, input MASK_SEL mask,
                               input logic [31:0] exp_rdata);
      int n;
      n = (mask == MASK_B) ? 1 : (mask == MASK_H) ? 2 : 4;
      if (port) begin
         req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata; mask1 = mask;
      end else begin
         req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata; mask0 = mask;
      end
      if (we)
         for (int i = 0; i < n; i++) wq.push_back('{addr + 32'(i), wdata[8*i +: 8]});
      rq.push_back('{port, we, exp_rdata, we ? n + 1 : n + 2, cyc});
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while ((rq.size() != 0 || wq.size() != 0) && k < 60) begin
         step();
         k++;
         if (rq.size() == 0) begin req0 = 1'b0; req1 = 1'b0; end
      end
      chk("pending_after_timeout", 64'(rq.size() + wq.size()), 64'd0);
      rq.delete();
      wq.delete();
      req0 = 1'b0;
      req1 = 1'b0;
      repeat (2) step();
   endtask

   task automatic do_access(input bit port, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input MASK_SEL mask,
                            input logic [31:0] exp_rdata);
      start_access(port, we, addr, wdata, mask, exp_rdata);
      wait_idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
      mask0 = MASK_W; mask1 = MASK_W;
      cur_rd[0] = 0; cur_rd[1] = 0;
      reset = 1'b1;
      repeat (2) step();
      chk("rst_ack", 64'({ack1, ack0}), 64'd0);
      chk("rst_bram_we", 64'(bram_we), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_grant", 64'(grant), 64'd1);
      chk("rst_rdata0", 64'(rdata0), 64'd0);
      chk("rst_rdata1", 64'(rdata1), 64'd0);
      chk("rst_bram_addr", 64'({bram_waddr, bram_raddr}), 64'd0);
      chk("rst_bram_wdata", 64'(bram_wdata), 64'd0);
      reset = 1'b0;

      // word write then read-back on port 0
      do_access(0, 1, 32'h100, 32'hDEADBEEF, MASK_X, 32'h0);
      do_access(0, 0, 32'h100, 32'h0, MASK_W, 32'hDEADBEEF);

      // byte write on port 1, then word/half/byte reads
      do_access(1, 1, 32'h101, 32'hAAAAAA55, MASK_B, 32'h0);
      chk("grant_port1", 64'(grant), 64'd1);
      do_access(0, 0, 32'h100, 32'h0, MASK_W, 32'hDEAD55EF);
      chk("grant_port0", 64'(grant), 64'd0);
      do_access(0, 0, 32'h102, 32'h0, MASK_H, 32'h0000DEAD);
      do_access(1, 0, 32'h101, 32'h0, MASK_B, 32'h00000055);

      // address wrap across 2^32
      do_access(0, 1, 32'hFFFFFFFE, 32'h01020304, MASK_W, 32'h0);
      do_access(1, 0, 32'hFFFFFFFE, 32'h0, MASK_W, 32'h01020304);

      // request fields changed and req dropped mid-transaction
      start_access(0, 1, 32'h300, 32'hCAFEF00D, MASK_W, 32'h0);
      step();
      step();
      req0 = 1'b0; addr0 = 32'h400; wdata0 = 32'h0; mask0 = MASK_B; we0 = 1'b0;
      wait_idle();
      do_access(0, 0, 32'h300, 32'h0, MASK_W, 32'hCAFEF00D);
      do_access(0, 0, 32'h400, 32'h0, MASK_B, 32'h0);

      // reset during byte 1 of a word write
      do_access(0, 1, 32'h200, 32'h11223344, MASK_W, 32'h0);
      req0 = 1'b1; we0 = 1'b1; addr0 = 32'h200; wdata0 = 32'hAABBCCDD; mask0 = MASK_W;
      wq.push_back('{32'h200, 8'hDD});
      wq.push_back('{32'h201, 8'hCC});
      step();
      step();
      reset = 1'b1;
      req0 = 1'b0;
      step();
      chk("midrst_bram_we", 64'(bram_we), 64'd0);
      chk("midrst_ack", 64'({ack1, ack0}), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_wq_empty", 64'(wq.size()), 64'd0);
      reset = 1'b0;
      cur_rd[0] = 0;
      cur_rd[1] = 0;
      repeat (2) step();
      do_access(0, 0, 32'h200, 32'h0, MASK_W, 32'h1122CCDD);

      // both ports requesting continuously from reset: 0,1,0,1
      reset = 1'b1;
      step();
      reset = 1'b0;
      cur_rd[0] = 0;
      cur_rd[1] = 0;
      hold_req = 1'b1;
      start_access(0, 0, 32'h100, 32'h0, MASK_W, 32'hDEAD55EF);
      start_access(1, 0, 32'h102, 32'h0, MASK_H, 32'h0000DEAD);
      start_access(0, 0, 32'h100, 32'h0, MASK_W, 32'hDEAD55EF);
      start_access(1, 0, 32'h102, 32'h0, MASK_H, 32'h0000DEAD);
      wait_idle();
      hold_req = 1'b0;
      chk("final_busy", 64'(busy), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
